// File: rtl/sata_identify_requester_if.sv
// Transmit-frame handshake between the IDENTIFY requester and the link layer.
//   o_dat    : FIS dword driven by the requester
//   o_val    : o_dat is valid
//   o_eop    : o_dat is the last dword of the FIS
//   i_rdy    : link layer accepts o_dat when o_val & i_rdy
//   i_tx_err : link layer reports a failed transmission
interface sata_identify_requester_if;
    logic [31:0] o_dat;
    logic        o_val;
    logic        o_eop;
    logic        i_rdy;
    logic        i_tx_err;

    modport master (output o_dat, o_val, o_eop, input i_rdy, i_tx_err);
    modport slave  (input o_dat, o_val, o_eop, output i_rdy, i_tx_err);
endinterface

// File: rtl/sata_identify_requester.sv
// Issues an IDENTIFY DEVICE H2D Register FIS, waits for the parser to report
// completion, retries on timeout / transmit error / bad checksum, and latches
// the device capabilities.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : request a run (honoured in IDLE, DONE, FAIL)
//   tx                  : transmit frame interface (master side)
//   identify_done       : parser completion level (rising edge is used)
//   bad_checksum        : parser CRC-error flag
//   sata1/2/3_supported : parser capability bits
//   max_lba_in          : parser max LBA
//   busy                : sending or waiting
//   info_valid          : results latched and valid
//   fail                : all attempts exhausted
//   sata_gen            : highest supported generation (0..3)
//   max_lba_address     : latched max LBA
//   attempt_cnt         : attempts made in the current run
module sata_identify_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    sata_identify_requester_if.master            tx,
    input  logic                                 identify_done,
    input  logic                                 bad_checksum,
    input  logic                                 sata1_supported,
    input  logic                                 sata2_supported,
    input  logic                                 sata3_supported,
    input  logic [47:0]                          max_lba_in,
    output logic                                 busy,
    output logic                                 info_valid,
    output logic                                 fail,
    output logic [1:0]                           sata_gen,
    output logic [47:0]                          max_lba_address,
    output logic [$clog2(MAX_RETRIES+2)-1:0]     attempt_cnt
);
    localparam int unsigned ACW = $clog2(MAX_RETRIES + 2);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ACW-1:0] MAX_ATT    = ACW'(MAX_RETRIES);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  TIMER_SAT  = TW'(TIMEOUT_CYCLES);

    // S_GAP is the one-cycle o_val=0 pause that precedes a resend.
    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_SEND, S_WAIT, S_DONE, S_FAIL
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [ACW-1:0] att_q, att_d;
    logic [1:0]     gen_q, gen_d;
    logic [47:0]    lba_q, lba_d;
    logic           done_prev_q;
    logic           done_rise;
    logic           retry;

    assign done_rise = identify_done & ~done_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            timer_q     <= '0;
            att_q       <= '0;
            gen_q       <= '0;
            lba_q       <= '0;
            done_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            att_q       <= att_d;
            gen_q       <= gen_d;
            lba_q       <= lba_d;
            done_prev_q <= identify_done;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        att_d   = att_q;
        gen_d   = gen_q;
        lba_d   = lba_q;
        retry   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d = S_SEND;
                    att_d   = ACW'(1);
                    idx_d   = '0;
                end
            end
            S_GAP: begin
                if (tx.i_tx_err) retry = 1'b1;
                else             state_d = S_SEND;
            end
            S_SEND: begin
                if (tx.i_tx_err) begin
                    retry = 1'b1;
                end else if (tx.i_rdy) begin
                    if (idx_q == 3'd4) begin
                        state_d = S_WAIT;
                        timer_d = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_WAIT: begin
                if (timer_q != TIMER_SAT) timer_d = timer_q + TW'(1);
                // Transmit error outranks both completion and timeout.
                if (tx.i_tx_err) begin
                    retry = 1'b1;
                end else if (done_rise) begin
                    if (bad_checksum) begin
                        retry = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        lba_d   = max_lba_in;
                        gen_d   = sata3_supported ? 2'd3 :
                                  sata2_supported ? 2'd2 :
                                  sata1_supported ? 2'd1 : 2'd0;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    retry = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (retry) begin
            if (att_q <= MAX_ATT) begin
                state_d = S_GAP;
                att_d   = att_q + ACW'(1);
                idx_d   = '0;
            end else begin
                state_d = S_FAIL;
            end
        end
    end

    always_comb begin
        tx.o_val        = (state_q == S_SEND);
        tx.o_eop        = tx.o_val && (idx_q == 3'd4);
        tx.o_dat        = '0;
        if (tx.o_val) begin
            case (idx_q)
                3'd0:    tx.o_dat = 32'h00EC8027;
                3'd1:    tx.o_dat = 32'hA0000000;
                default: tx.o_dat = '0;
            endcase
        end
        busy            = (state_q == S_SEND) || (state_q == S_GAP) || (state_q == S_WAIT);
        info_valid      = (state_q == S_DONE);
        fail            = (state_q == S_FAIL);
        sata_gen        = gen_q;
        max_lba_address = lba_q;
        attempt_cnt     = att_q;
    end
endmodule

// File: tb/tb_sata_identify_requester.sv
module tb_sata_identify_requester;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        identify_done = 1'b0;
    logic        bad_checksum = 1'b0;
    logic        s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic [47:0] lba_in = '0;
    logic        busy, info_valid, fail;
    logic [1:0]  sata_gen;
    logic [47:0] max_lba_address;
    logic [2:0]  attempt_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] fis [5];

    sata_identify_requester_if tx_if ();

    sata_identify_requester #(.TIMEOUT_CYCLES(50), .MAX_RETRIES(3)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .tx(tx_if),
        .identify_done(identify_done), .bad_checksum(bad_checksum),
        .sata1_supported(s1), .sata2_supported(s2), .sata3_supported(s3),
        .max_lba_in(lba_in), .busy(busy), .info_valid(info_valid), .fail(fail),
        .sata_gen(sata_gen), .max_lba_address(max_lba_address),
        .attempt_cnt(attempt_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Highest supported generation: the largest generation whose bit is set.
    function automatic logic [1:0] model_gen(input logic a, input logic b, input logic c);
        logic [1:0] g = 2'd0;
        if (a) g = 2'd1;
        if (b) g = 2'd2;
        if (c) g = 2'd3;
        return g;
    endfunction

    task automatic randomize_caps();
        s1 = 1'($urandom); s2 = 1'($urandom); s3 = 1'($urandom);
        lba_in = {16'($urandom), 32'($urandom)};
    endtask

    // Collects one FIS from the link side. mode 0: i_rdy=1, 1: toggle, 2: random.
    task automatic send_fis(input int mode, input string tag);
        int n = 0;
        logic held = 1'b0;
        logic [31:0] held_dat = '0;
        logic rdy;
        for (int cyc = 0; cyc < 200 && n < 5; cyc++) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom);
            tx_if.i_rdy = rdy;
            if (tx_if.o_val) begin
                if (held) chk({tag, "_hold"}, 64'(tx_if.o_dat), 64'(held_dat));
                if (rdy) begin
                    chk({tag, "_dat"}, 64'(tx_if.o_dat), 64'(fis[n]));
                    chk({tag, "_eop"}, 64'(tx_if.o_eop), 64'(n == 4));
                    n++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_dat = tx_if.o_dat;
                end
            end
            tick();
        end
        tx_if.i_rdy = 1'b1;
        chk({tag, "_xfers"}, 64'(n), 64'd5);
    endtask

    task automatic check_done(input string tag, input int att);
        chk({tag, "_info_valid"}, 64'(info_valid), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_gen"}, 64'(sata_gen), 64'(model_gen(s1, s2, s3)));
        chk({tag, "_lba"}, 64'(max_lba_address), 64'(lba_in));
        chk({tag, "_attempt"}, 64'(attempt_cnt), 64'(att));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_latency_val", 64'(tx_if.o_val), 64'd1);
    endtask

    initial begin
        fis[0] = 32'h00EC8027; fis[1] = 32'hA0000000;
        fis[2] = '0; fis[3] = '0; fis[4] = '0;
        tx_if.i_rdy = 1'b1;
        tx_if.i_tx_err = 1'b0;

        // Reset state
        #12;
        chk("rst_val", 64'(tx_if.o_val), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_attempt", 64'(attempt_cnt), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Nominal
        randomize_caps();
        s3 = 1'b1;
        lba_in = 48'h0000_0E8E_0880;
        do_start();
        send_fis(0, "nom");
        repeat (19) tick();
        chk("nom_wait_busy", 64'(busy), 64'd1);
        identify_done = 1'b1;
        tick();
        check_done("nom", 1);
        identify_done = 1'b0;
        tick();

        // Backpressure with random capabilities
        randomize_caps();
        do_start();
        send_fis(1, "bp");
        repeat ($urandom_range(1, 40)) tick();
        identify_done = 1'b1;
        tick();
        check_done("bp", 1);
        identify_done = 1'b0;
        tick();

        // Bad checksum on first attempt, clean on second
        randomize_caps();
        do_start();
        send_fis(2, "bc1");
        repeat ($urandom_range(0, 30)) tick();
        identify_done = 1'b1;
        bad_checksum = 1'b1;
        tick();
        chk("bc_gap_val", 64'(tx_if.o_val), 64'd0);
        chk("bc_gap_busy", 64'(busy), 64'd1);
        chk("bc_gap_attempt", 64'(attempt_cnt), 64'd2);
        identify_done = 1'b0;
        bad_checksum = 1'b0;
        tick();
        chk("bc_resend_val", 64'(tx_if.o_val), 64'd1);
        send_fis(0, "bc2");
        repeat ($urandom_range(0, 30)) tick();
        identify_done = 1'b1;
        tick();
        check_done("bc", 2);
        identify_done = 1'b0;
        tick();

        // Timeout exhaustion
        do_start();
        for (int a = 1; a <= 4; a++) begin
            chk("to_attempt", 64'(attempt_cnt), 64'(a));
            send_fis(2, "to");
            repeat (49) tick();
            chk("to_wait_busy", 64'(busy), 64'd1);
            chk("to_wait_fail", 64'(fail), 64'd0);
            tick();
            if (a < 4) begin
                chk("to_gap_val", 64'(tx_if.o_val), 64'd0);
                chk("to_gap_busy", 64'(busy), 64'd1);
                tick();
            end
        end
        chk("to_fail", 64'(fail), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_attempt_final", 64'(attempt_cnt), 64'd4);
        chk("to_info_valid", 64'(info_valid), 64'd0);

        // Transmit errors: mid-FIS, with timeout, with done (tx_err wins)
        randomize_caps();
        do_start();
        tick();
        tick();
        chk("txe_dword2", 64'(tx_if.o_dat), 64'(fis[2]));
        tx_if.i_tx_err = 1'b1;
        tick();
        tx_if.i_tx_err = 1'b0;
        chk("txe1_gap_val", 64'(tx_if.o_val), 64'd0);
        chk("txe1_attempt", 64'(attempt_cnt), 64'd2);
        tick();
        chk("txe1_restart_dat", 64'(tx_if.o_dat), 64'(fis[0]));
        send_fis(0, "txe2");
        repeat (49) tick();
        tx_if.i_tx_err = 1'b1;
        tick();
        tx_if.i_tx_err = 1'b0;
        chk("txe2_gap_val", 64'(tx_if.o_val), 64'd0);
        chk("txe2_attempt", 64'(attempt_cnt), 64'd3);
        tick();
        send_fis(0, "txe3");
        repeat (5) tick();
        identify_done = 1'b1;
        tx_if.i_tx_err = 1'b1;
        tick();
        chk("txe3_not_done", 64'(info_valid), 64'd0);
        chk("txe3_gap_busy", 64'(busy), 64'd1);
        chk("txe3_attempt", 64'(attempt_cnt), 64'd4);
        identify_done = 1'b0;
        tx_if.i_tx_err = 1'b0;
        tick();
        send_fis(0, "txe4");
        repeat (3) tick();
        identify_done = 1'b1;
        tick();
        check_done("txe4", 4);
        identify_done = 1'b0;
        tick();

        // Stale done level, then reset during SEND
        identify_done = 1'b1;
        tick();
        do_start();
        send_fis(0, "stale");
        repeat (30) tick();
        chk("stale_no_done", 64'(info_valid), 64'd0);
        chk("stale_busy", 64'(busy), 64'd1);
        repeat (20) tick();
        chk("stale_gap_val", 64'(tx_if.o_val), 64'd0);
        chk("stale_attempt", 64'(attempt_cnt), 64'd2);
        tick();
        chk("stale_resend_val", 64'(tx_if.o_val), 64'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_val", 64'(tx_if.o_val), 64'd0);
        chk("arst_dat", 64'(tx_if.o_dat), 64'd0);
        chk("arst_eop", 64'(tx_if.o_eop), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_info", 64'(info_valid), 64'd0);
        chk("arst_fail", 64'(fail), 64'd0);
        chk("arst_gen", 64'(sata_gen), 64'd0);
        chk("arst_lba", 64'(max_lba_address), 64'd0);
        chk("arst_attempt", 64'(attempt_cnt), 64'd0);
        identify_done = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
